// File: rtl/riscv_hwloop_bank.sv
// Hardware-loop register bank: N_LOOPS start/end/count sets, innermost-first loop-end
// matching with combinational jump-back, commit-driven decrement and a registered CSR read port.
module riscv_hwloop_bank #(
   parameter int N_LOOPS = 2,
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 32,
   parameter int ID_W    = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        we_i,
   input  logic [ID_W-1:0]   wr_id_i,
   input  logic [ADDR_W-1:0] start_data_i,
   input  logic [ADDR_W-1:0] end_data_i,
   input  logic [CNT_W-1:0]  cnt_data_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              pc_valid_i,
   input  logic              commit_i,
   input  logic              clear_i,
   output logic              jump_o,
   output logic [ADDR_W-1:0] jump_target_o,
   output logic [ID_W-1:0]   match_id_o,
   output logic [N_LOOPS-1:0] active_o,
   input  logic              rd_req_i,
   input  logic [ID_W-1:0]   rd_id_i,
   input  logic [1:0]        rd_sel_i,
   output logic              rd_valid_o,
   output logic [31:0]       rd_data_o
);

   logic [ADDR_W-1:0] start_q [N_LOOPS];
   logic [ADDR_W-1:0] end_q   [N_LOOPS];
   logic [CNT_W-1:0]  cnt_q   [N_LOOPS];

   logic [N_LOOPS-1:0] match;
   logic               found;
   logic [ID_W-1:0]    sel;
   logic [ADDR_W-1:0]  sel_start;
   logic [CNT_W-1:0]   sel_cnt;
   logic [31:0]        rd_mux;

   always_comb begin
      for (int k = 0; k < N_LOOPS; k++) begin
         active_o[k] = (cnt_q[k] != '0);
         match[k]    = active_o[k] && pc_valid_i && (end_q[k] == pc_i);
      end
   end

   // Scan from the outermost set down so the lowest matching index is the one left selected.
   always_comb begin
      found     = 1'b0;
      sel       = '0;
      sel_start = '0;
      sel_cnt   = '0;
      for (int k = N_LOOPS - 1; k >= 0; k--) begin
         if (match[k]) begin
            found     = 1'b1;
            sel       = ID_W'(k);
            sel_start = start_q[k];
            sel_cnt   = cnt_q[k];
         end
      end
   end

   // A final iteration (count 1) falls through instead of jumping back.
   assign jump_o        = found && (sel_cnt > CNT_W'(1));
   assign jump_target_o = sel_start;
   assign match_id_o    = sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_LOOPS; k++) begin
            start_q[k] <= '0;
            end_q[k]   <= '0;
            cnt_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < N_LOOPS; k++) begin
            if (we_i[0] && (wr_id_i == ID_W'(k))) start_q[k] <= start_data_i;
            if (we_i[1] && (wr_id_i == ID_W'(k))) end_q[k]   <= end_data_i;
            if (clear_i)
               cnt_q[k] <= '0;
            else if (we_i[2] && (wr_id_i == ID_W'(k)))
               cnt_q[k] <= cnt_data_i;
            else if (commit_i && found && (sel == ID_W'(k)))
               cnt_q[k] <= cnt_q[k] - CNT_W'(1);
         end
      end
   end

   // An id that matches no set leaves the field read at zero; the bitmap ignores the id.
   always_comb begin
      rd_mux = '0;
      if (rd_sel_i == 2'd3) begin
         rd_mux = 32'(active_o);
      end else begin
         for (int k = 0; k < N_LOOPS; k++) begin
            if (rd_id_i == ID_W'(k)) begin
               case (rd_sel_i)
                  2'd0:    rd_mux = 32'(start_q[k]);
                  2'd1:    rd_mux = 32'(end_q[k]);
                  default: rd_mux = 32'(cnt_q[k]);
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
      end else begin
         rd_valid_o <= rd_req_i;
         if (rd_req_i) rd_data_o <= rd_mux;
      end
   end

endmodule

// File: doc/riscv_hwloop_bank.md
# riscv_hwloop_bank

Parametrised hardware-loop register bank with integrated loop-end matching, for RI5CY-class cores. It holds start/end/count for `N_LOOPS` loop sets. Each cycle it compares the ID-stage PC against every active loop end, picks the innermost match, and drives the jump-back target. It decrements that loop's counter on commit. A registered CSR read port exposes every field plus an active-loop bitmap. It sits between the EX-stage hwloop setup path, the IF/ID jump logic and the CSR file.

## Interface
- `N_LOOPS`, 2: number of loop register sets, 1..8.
- `ADDR_W`, 32: width of start/end addresses, ≤32.
- `CNT_W`, 32: counter width, ≤32.
- `ID_W`, `$clog2(N_LOOPS)` (min 1): loop index width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `we_i` in 3: write enables; [0]=start, [1]=end, [2]=count.
- `wr_id_i` in `ID_W`: target set for writes.
- `start_data_i` in `ADDR_W`: start address.
- `end_data_i` in `ADDR_W`: end address.
- `cnt_data_i` in `CNT_W`: count.
- `pc_i` in `ADDR_W`: address of the instruction in ID.
- `pc_valid_i` in 1: `pc_i` is meaningful.
- `commit_i` in 1: the instruction at `pc_i` is committed this cycle.
- `clear_i` in 1: zero all counters, which deactivates every loop.
- `jump_o` out 1: branch to `jump_target_o`.
- `jump_target_o` out `ADDR_W`: start address of the selected loop.
- `match_id_o` out `ID_W`: index of the selected loop.
- `active_o` out `N_LOOPS`: bit k = counter k ≠ 0.
- `rd_req_i` in 1: CSR read request.
- `rd_id_i` in `ID_W`: set to read.
- `rd_sel_i` in 2: field to read; 0=start, 1=end, 2=count, 3=`active_o` bitmap.
- `rd_valid_o` out 1: read data valid.
- `rd_data_o` out 32: read data, zero-extended.

## Operation
- **Active loop:** set k is active iff `cnt_q[k] != 0`.
- **Match:** k matches iff it is active, `pc_valid_i` = 1 and `end_q[k] == pc_i`.
- **Selection:** the lowest matching index wins (index 0 = innermost). Other matches are ignored this cycle.
- **`jump_o`:** asserted iff a selected loop exists and its `cnt_q > 1`. With count == 1 the PC falls through and `jump_o` = 0.
- **Jump outputs are combinational:**
  - `jump_target_o` = `start_q[sel]`, or 0 when nothing is selected.
  - `match_id_o` = sel, or 0 when nothing is selected.
- **Decrement:** when `commit_i` and a selected loop exists, `cnt_q[sel]` <= `cnt_q[sel] - 1`. Only active loops decrement, so no wrap below 0 is possible.
- **Counter update priority, per set:** `clear_i` > count write > decrement.
  - A count write to set j and a decrement of set k≠j in the same cycle both take effect.
  - A count write to j and a decrement of j: the write wins.
- **Start/end writes:** independent of count writes. All three fields may be written in one cycle.
- **Out-of-range index:** a `wr_id_i` ≥ `N_LOOPS` ignores the write. A `rd_id_i` ≥ `N_LOOPS` returns 0; `rd_sel_i` = 3 still returns the bitmap.
- **`clear_i`:** zeros counters only. Start/end registers are retained.
- **CSR read:** registered.
  - `rd_valid_o` = `rd_req_i` delayed by one cycle.
  - `rd_data_o` is captured from the pre-update `_q` values of the request cycle.
  - `rd_data_o` holds its value while `rd_req_i` = 0.

## Timing
- **Reset:** all start/end/count registers = 0, `active_o` = 0, `jump_o` = 0, `jump_target_o` = 0, `match_id_o` = 0, `rd_valid_o` = 0, `rd_data_o` = 0.
- **Writes:** visible to match, `active_o` and reads from the next cycle. No same-cycle bypass.
- **Jump path:** combinational from `pc_i` and `_q` to `jump_o` / `jump_target_o`, zero cycles. The decrement lands at the next clock edge.
- **Read latency:** exactly 1 cycle. Back-to-back requests are allowed every cycle.
- **Reset mid-operation:** all state clears asynchronously, and `rd_valid_o` drops immediately.

## Test plan
- Write set 0 with start=0x100, end=0x120, cnt=3. Present `pc_i`=0x120 with commit for 3 cycles. Required: `jump_o` = 1, 1, 0; `jump_target_o` = 0x100; counter goes 2, 1, 0; `active_o[0]` drops after the third commit.
- Nested loops: set 0 has end 0x140, cnt 2; set 1 has end 0x140, cnt 5. At `pc_i`=0x140 with commit, required: `match_id_o` = 0; only set 0 decrements; set 1 stays at 5.
- Count write to set 1 (cnt=7) in the same cycle as a commit-decrement of set 1 (cnt 4). Required: counter = 7 next cycle. Repeat with the write targeting set 0 instead: required set 0 = 7 and set 1 = 3.
- With cnt=0, `pc_i` equal to the end address and commit: required `jump_o` = 0 and no counter change. Then assert `clear_i` with active loops: required `active_o` = 0 next cycle, start/end unchanged.
- CSR read of count for set 1 while set 1 decrements from 9: required `rd_valid_o` = 1 one cycle later with `rd_data_o` = 9. Read with `rd_sel_i` = 3: required `rd_data_o` = the `active_o` bitmap. Read with an out-of-range id: required `rd_data_o` = 0.
- Assert `rst_n` low mid-loop (cnt=4, read pending). Required: all outputs 0 asynchronously, and a new loop runs correctly after release.
